cmd_exec_ctrl: RTL and testbench
================================

# cmd_exec_ctrl

Command execution controller downstream of the RX command chain. Pops decoded `cmd_packet_t` entries from the command FIFO and sequences one memory access per command over a req/ack bus. Then writes a status byte, plus read data for reads, into the TX byte FIFO. It serializes all memory traffic and owns the response path.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width; matches `cmd_packet_t.addr`.
- `TIMEOUT`, 255: maximum cycles `mem_req` may wait for `mem_ack`; legal range 1..255.

Ports:
- `clk`, in, 1: single clock. All state is in this domain.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_fifo_empty`, in, 1: command FIFO empty.
- `cmd_fifo_rd_en`, out, 1: pop request, one-cycle pulse.
- `cmd_fifo_valid`, in, 1: `cmd_fifo_rd_data` valid this cycle. Arrives one or more cycles after `rd_en`.
- `cmd_fifo_rd_data`, in, `cmd_packet_t`: fields used are `opcode[7:0]`, `addr[ADDR_W-1:0]` and `data[7:0]`.
- `mem_req`, out, 1: access request, held until ack or timeout.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_addr`, out, ADDR_W: access address.
- `mem_wdata`, out, 8: write data.
- `mem_rdata`, in, 8: read data, sampled in the `mem_ack` cycle.
- `mem_ack`, in, 1: access complete, one-cycle pulse.
- `tx_fifo_full`, in, 1: TX byte FIFO full.
- `tx_fifo_wr_en`, out, 1: TX push.
- `tx_fifo_wr_data`, out, 8: TX byte.
- `busy`, out, 1: high when the state is not IDLE.
- `err_count`, out, 8: count of NAKs issued; saturates at 255.

## Operation
Opcodes:
- 0x57 (`'W'`): write `data` to `addr`.
- 0x52 (`'R'`): read `addr`.
- Any other value is illegal.

Response bytes:
- ACK = 0x06.
- NAK = 0x15.
- A successful read returns ACK followed by the read byte.
- A write, an illegal opcode, or a timeout returns a single status byte only.

State machine:
- IDLE: `cmd_fifo_rd_en` = `!cmd_fifo_empty`, combinational. If not empty, go to WAIT_CMD.
- WAIT_CMD: hold until `cmd_fifo_valid`, then latch opcode, addr and data, and go to DECODE.
- DECODE (1 cycle):
  - Legal opcode: go to MEM and clear the timeout counter.
  - Illegal opcode: status = NAK, increment `err_count`, go to RESP0.
- MEM: `mem_req`=1. `mem_we`, `mem_addr` and `mem_wdata` come from latched fields and are stable for the whole state.
  - `mem_ack`=1: capture `mem_rdata`, status = ACK, go to RESP0.
  - Counter == TIMEOUT-1 with no ack: status = NAK, increment `err_count`, go to RESP0.
  - Otherwise: increment the counter.
- RESP0: `tx_fifo_wr_en` = `!tx_fifo_full`, with data = status.
  - On push, if the command was a read with ACK status, go to RESP1; otherwise go to IDLE.
  - While full, hold.
- RESP1: `tx_fifo_wr_en` = `!tx_fifo_full`, with data = captured read byte. On push, go to IDLE.

Boundary rules:
- `mem_ack` in the same cycle the timeout limit is reached: the ack wins and the response is ACK.
- `mem_ack` outside MEM is ignored.
- `cmd_fifo_valid` outside WAIT_CMD is ignored.
- `err_count` holds at 255 once saturated and never wraps.
- The latched command does not change between DECODE and the return to IDLE.

Reset (any state, including mid-MEM or mid-RESP):
- Next state is IDLE.
- `mem_req`, `cmd_fifo_rd_en` and `tx_fifo_wr_en` are 0 from the cycle after the reset edge.
- `err_count`, the counter and the latches are cleared.
- An in-flight command is dropped with no response.

## Timing
- Reset values: every output is 0.
- `cmd_fifo_rd_en` is high for exactly one cycle per command.
- `mem_req` and `busy` are registered decodes of state.
- `tx_fifo_wr_en` is a combinational decode of state and `tx_fifo_full`.
- Write command, with `cmd_fifo_valid` one cycle after `rd_en`, ack on the first `mem_req` cycle, and TX not full:
  - IDLE (rd_en) → WAIT_CMD (valid) → DECODE → MEM (ack) → RESP0 (push) → IDLE.
  - This is 5 cycles, with a new `rd_en` possible on cycle 6.
- A read adds 1 cycle for RESP1.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, and the NAK is pushed on the next cycle.
- Exactly one memory access is outstanding at any time; there is no command pipelining.

## Test plan
- Write: cmd {0x57, 0x0010, 0xA5}, ack after 3 cycles. Expect `mem_req` high for 3 cycles with `we`=1, addr 0x0010 and wdata 0xA5, then the TX byte 0x06.
- Read: cmd {0x52, 0x0010}, `mem_rdata`=0xA5 with ack. Expect TX bytes 0x06 then 0xA5 on consecutive cycles. `busy` drops the cycle after.
- Illegal opcode 0x41: expect no `mem_req`, TX 0x15, `err_count`=1.
- Timeout with TIMEOUT=4 and no ack: expect `mem_req` high 4 cycles, TX 0x15, `err_count` incremented. A second run where ack lands on the 4th cycle must produce ACK.
- Backpressure: `tx_fifo_full`=1 for 10 cycles during a read response. Expect no push while full, then 0x06 and 0xA5 in order, with no byte lost or duplicated.
- Reset mid-MEM: assert `rst` on the 2nd `mem_req` cycle. Expect `mem_req`=0 next cycle, `busy`=0, no TX push, and the following command executes normally.

Source files
------------

// File: rtl/cmd_exec_ctrl.sv
// cmd_exec_ctrl
//   Pops decoded commands from the command FIFO and runs one memory access per
//   command over a req/ack bus. Each command gets a status byte in the TX byte
//   FIFO. A successful read also gets the read byte. Only one access is ever
//   outstanding.
//
// Ports
//   clk, rst            : single clock; synchronous active-high reset
//   cmd_fifo_*          : command FIFO pop side (empty, rd_en, valid, rd_data)
//   mem_req/we/addr/wdata/rdata/ack : memory access bus, req held until ack/timeout
//   tx_fifo_full/wr_en/wr_data      : TX byte FIFO push side
//   busy                : state is not IDLE
//   err_count           : NAKs issued, saturating at 255

package cmd_exec_pkg;
    localparam int CMD_ADDR_W = 16;

    typedef struct packed {
        logic [7:0]            opcode;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } cmd_packet_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
endpackage

module cmd_exec_ctrl
    import cmd_exec_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_fifo_empty,
    output logic              cmd_fifo_rd_en,
    input  logic              cmd_fifo_valid,
    input  cmd_packet_t       cmd_fifo_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    input  logic              tx_fifo_full,
    output logic              tx_fifo_wr_en,
    output logic [7:0]        tx_fifo_wr_data,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CMD,
        S_DECODE,
        S_MEM,
        S_RESP0,
        S_RESP1
    } state_t;

    // The counter reaches TIMEOUT-1 on the TIMEOUT-th request cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        status_q;
    logic [7:0]        rdata_q;
    logic [7:0]        tmo_cnt;

    // The pop request is gated by rst so that it stays low for the whole
    // reset period, even though the state is already IDLE by then.
    assign cmd_fifo_rd_en  = !rst && (state == S_IDLE) && !cmd_fifo_empty;
    assign tx_fifo_wr_en   = ((state == S_RESP0) || (state == S_RESP1)) && !tx_fifo_full;
    assign tx_fifo_wr_data = (state == S_RESP1) ? rdata_q : status_q;

    // The bus fields come straight from the command latches. The latches only
    // change in WAIT_CMD, so the fields are stable for the whole MEM state.
    assign mem_we    = (opcode_q == OP_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

    // NOTE: every register here, including the command latches and the read
    // byte, is cleared by the synchronous reset. After reset all outputs are
    // 0, and a dropped command leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
            opcode_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            tmo_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every branch below
            // reads the values from before this edge.
            case (state)
                S_IDLE: begin
                    if (!cmd_fifo_empty) begin
                        state <= S_WAIT_CMD;
                        busy  <= 1'b1;
                    end
                end

                S_WAIT_CMD: begin
                    if (cmd_fifo_valid) begin
                        opcode_q <= cmd_fifo_rd_data.opcode;
                        addr_q   <= cmd_fifo_rd_data.addr[ADDR_W-1:0];
                        data_q   <= cmd_fifo_rd_data.data;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if ((opcode_q == OP_WRITE) || (opcode_q == OP_READ)) begin
                        tmo_cnt <= '0;
                        mem_req <= 1'b1;
                        state   <= S_MEM;
                    end else begin
                        status_q <= RSP_NAK;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        state    <= S_RESP0;
                    end
                end

                S_MEM: begin
                    // The ack is tested first, so an ack in the limit cycle wins.
                    if (mem_ack) begin
                        rdata_q  <= mem_rdata;
                        status_q <= RSP_ACK;
                        mem_req  <= 1'b0;
                        state    <= S_RESP0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        status_q <= RSP_NAK;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        mem_req  <= 1'b0;
                        state    <= S_RESP0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                S_RESP0: begin
                    if (!tx_fifo_full) begin
                        if ((opcode_q == OP_READ) && (status_q == RSP_ACK)) begin
                            state <= S_RESP1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                S_RESP1: begin
                    if (!tx_fifo_full) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Testbench for cmd_exec_ctrl: directed commands, scoreboard queues for the
// expected memory accesses and TX bytes, and independent monitor processes.
module tb_cmd_exec_ctrl;
    import cmd_exec_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_fifo_empty = 1'b1;
    logic              cmd_fifo_rd_en;
    logic              cmd_fifo_valid;
    cmd_packet_t       cmd_fifo_rd_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              tx_fifo_full = 1'b0;
    logic              tx_fifo_wr_en;
    logic [7:0]        tx_fifo_wr_data;
    logic              busy;
    logic [7:0]        err_count;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack_at;   // request cycle that carries the ack, 0 = never
        logic [7:0]  rdata;
        int          len;      // expected number of mem_req cycles
    } mem_exp_t;

    cmd_packet_t cmd_q[$];
    mem_exp_t    exp_mem[$];
    logic [7:0]  exp_tx[$];
    int          rd_cycles[$];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;
    int cyc      = 0;

    logic        drv_valid   = 1'b0;
    logic        drv_pending = 1'b0;
    logic        poke_valid  = 1'b0;
    logic        resp_ack    = 1'b0;
    logic        poke_ack    = 1'b0;
    logic        mem_active  = 1'b0;
    logic [7:0]  resp_rdata  = 8'hEE;
    cmd_packet_t drv_pkt     = '0;
    cmd_packet_t pend_pkt    = '0;
    cmd_packet_t poke_pkt    = '0;

    assign cmd_fifo_valid   = drv_valid | poke_valid;
    assign cmd_fifo_rd_data = poke_valid ? poke_pkt : drv_pkt;
    assign mem_ack          = resp_ack | poke_ack;
    assign mem_rdata        = resp_rdata;

    cmd_exec_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_fifo_empty   (cmd_fifo_empty),
        .cmd_fifo_rd_en   (cmd_fifo_rd_en),
        .cmd_fifo_valid   (cmd_fifo_valid),
        .cmd_fifo_rd_data (cmd_fifo_rd_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_wr_en    (tx_fifo_wr_en),
        .tx_fifo_wr_data  (tx_fifo_wr_data),
        .busy             (busy),
        .err_count        (err_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Queue one command with its expected memory access and response bytes.
    task automatic send(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] data,
                        input int ack_at, input logic [7:0] rdata, input int len,
                        input int nb, input logic [7:0] b0, input logic [7:0] b1);
        cmd_packet_t p;
        mem_exp_t    m;
        p.opcode = op;
        p.addr   = addr;
        p.data   = data;
        if (len > 0) begin
            m.we     = (op == 8'h57);
            m.addr   = addr;
            m.wdata  = data;
            m.ack_at = ack_at;
            m.rdata  = rdata;
            m.len    = len;
            exp_mem.push_back(m);
        end
        if (nb > 0) exp_tx.push_back(b0);
        if (nb > 1) exp_tx.push_back(b1);
        if (nb > 0 && b0 == 8'h15 && exp_err < 255) exp_err++;
        cmd_q.push_back(p);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < budget && !(cmd_q.size() == 0 && !drv_pending && !busy &&
                                   exp_tx.size() == 0 && exp_mem.size() == 0 && !mem_active));
        check({name, " reaches idle"}, 32'(n < budget), 32'd1);
        check({name, " err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    task automatic wait_mem_req(input string name, input logic lvl);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 100 && mem_req !== lvl);
        check({name, " mem_req level reached"}, 32'(mem_req), 32'(lvl));
    endtask

    task automatic wait_tx_push(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 100 && tx_fifo_wr_en !== 1'b1);
        check({name, " tx push seen"}, 32'(tx_fifo_wr_en), 32'd1);
    endtask

    // Command FIFO model: valid follows rd_en by one cycle, for one cycle.
    initial begin
        logic prev_rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            drv_valid = drv_pending;
            if (drv_pending) drv_pkt = pend_pkt;
            drv_pending    = 1'b0;
            cmd_fifo_empty = (cmd_q.size() == 0);
            @(negedge clk);
            if (cmd_fifo_rd_en) begin
                check("rd_en single cycle", 32'(prev_rd), 32'd0);
                check("rd_en with command queued", 32'(cmd_q.size() != 0), 32'd1);
                rd_cycles.push_back(cyc);
                if (cmd_q.size() != 0) begin
                    pend_pkt    = cmd_q.pop_front();
                    drv_pending = 1'b1;
                end
            end
            prev_rd = cmd_fifo_rd_en;
        end
    end

    // Memory responder and access monitor.
    initial begin
        mem_exp_t cur;
        int       req_len = 0;
        cur = '{1'b0, 16'h0, 8'h0, 0, 8'h0, 0};
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (!mem_active) begin
                    check("mem_req with access expected", 32'(exp_mem.size() != 0), 32'd1);
                    if (exp_mem.size() != 0) cur = exp_mem.pop_front();
                    else cur = '{1'b0, 16'h0, 8'h0, 0, 8'h0, 0};
                    mem_active = 1'b1;
                    req_len    = 0;
                    check("mem_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
                check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                req_len++;
                if (cur.ack_at == req_len) begin
                    resp_ack   = 1'b1;
                    resp_rdata = cur.rdata;
                    @(posedge clk);
                    #1;
                    resp_ack   = 1'b0;
                    resp_rdata = 8'hEE;
                end
            end else if (mem_active) begin
                check("mem_req length", 32'(req_len), 32'(cur.len));
                mem_active = 1'b0;
            end
        end
    end

    // TX monitor: every push is compared against the head of the queue.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_fifo_wr_en) begin
                check("tx no push while full", 32'(tx_fifo_full), 32'd0);
                check("tx push expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    b = exp_tx.pop_front();
                    check("tx byte", 32'(tx_fifo_wr_data), 32'(b));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset cmd_fifo_rd_en", 32'(cmd_fifo_rd_en), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset tx_fifo_wr_en", 32'(tx_fifo_wr_en), 32'd0);
        check("reset tx_fifo_wr_data", 32'(tx_fifo_wr_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);

        // Write, ack on the 3rd request cycle.
        send(8'h57, 16'h0010, 8'hA5, 3, 8'h00, 3, 1, 8'h06, 8'h00);
        wait_idle("write", 100);

        // Read: ACK then data on consecutive cycles, busy low right after.
        send(8'h52, 16'h0010, 8'h00, 1, 8'hA5, 1, 2, 8'h06, 8'hA5);
        wait_tx_push("read");
        @(negedge clk);
        check("read second byte consecutive", 32'(tx_fifo_wr_en), 32'd1);
        @(negedge clk);
        check("read busy drops", 32'(busy), 32'd0);
        wait_idle("read", 100);

        // Illegal opcode: no access, NAK, err_count = 1.
        send(8'h41, 16'h0033, 8'h77, 0, 8'h00, 0, 1, 8'h15, 8'h00);
        wait_idle("illegal", 100);

        // Timeout: 4 request cycles, NAK pushed in the very next cycle.
        send(8'h57, 16'h1234, 8'h5A, 0, 8'h00, 4, 1, 8'h15, 8'h00);
        wait_mem_req("timeout start", 1'b1);
        wait_mem_req("timeout end", 1'b0);
        check("timeout NAK push next cycle", 32'(tx_fifo_wr_en), 32'd1);
        check("timeout NAK byte", 32'(tx_fifo_wr_data), 32'h15);
        wait_idle("timeout", 100);

        // Ack in the limit cycle wins.
        send(8'h52, 16'h0BEE, 8'h00, 4, 8'h3C, 4, 2, 8'h06, 8'h3C);
        wait_idle("ack at limit", 100);

        // Backpressure on a read response.
        send(8'h52, 16'h00F0, 8'h00, 1, 8'hA5, 1, 2, 8'h06, 8'hA5);
        wait_mem_req("backpressure", 1'b1);
        tx_fifo_full = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("backpressure still busy", 32'(busy), 32'd1);
        check("backpressure bytes held", 32'(exp_tx.size()), 32'd2);
        tx_fifo_full = 1'b0;
        wait_idle("backpressure", 100);

        // Back-to-back writes: a new rd_en every 5 cycles.
        rd_cycles.delete();
        send(8'h57, 16'h0300, 8'h01, 1, 8'h00, 1, 1, 8'h06, 8'h00);
        send(8'h57, 16'h0301, 8'h02, 1, 8'h00, 1, 1, 8'h06, 8'h00);
        wait_idle("back-to-back", 100);
        check("back-to-back rd_en count", 32'(rd_cycles.size()), 32'd2);
        if (rd_cycles.size() >= 2)
            check("back-to-back rd_en spacing", 32'(rd_cycles[1] - rd_cycles[0]), 32'd5);

        // Stray ack and valid while idle must be ignored.
        @(posedge clk);
        #1;
        poke_pkt   = '{opcode: 8'h57, addr: 16'h0400, data: 8'h99};
        poke_ack   = 1'b1;
        poke_valid = 1'b1;
        @(posedge clk);
        #1;
        poke_ack   = 1'b0;
        poke_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stray inputs busy", 32'(busy), 32'd0);
        check("stray inputs mem_req", 32'(mem_req), 32'd0);

        // Reset on the 2nd request cycle drops the command.
        send(8'h57, 16'h0200, 8'h11, 0, 8'h00, 2, 0, 8'h00, 8'h00);
        wait_mem_req("reset mid-mem", 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("reset mid-mem mem_req", 32'(mem_req), 32'd0);
        check("reset mid-mem busy", 32'(busy), 32'd0);
        check("reset mid-mem tx_fifo_wr_en", 32'(tx_fifo_wr_en), 32'd0);
        wait_idle("reset mid-mem", 100);
        send(8'h57, 16'h0201, 8'h22, 2, 8'h00, 2, 1, 8'h06, 8'h00);
        wait_idle("after reset", 100);

        // err_count saturation.
        for (int i = 0; i < 260; i++)
            send(8'h41, 16'(i), 8'h00, 0, 8'h00, 0, 1, 8'h15, 8'h00);
        wait_idle("saturation", 5000);
        check("saturation err_count 255", 32'(err_count), 32'd255);

        check("cmd queue drained", 32'(cmd_q.size()), 32'd0);
        check("tx queue drained", 32'(exp_tx.size()), 32'd0);
        check("mem queue drained", 32'(exp_mem.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
